// File: rtl/c7b_rd_arb.sv
// Read arbiter between the instruction fetch unit and the load/store unit onto one AXI
// read channel. Only one read is outstanding at a time. The LSU normally wins a
// conflict, but the IFU is forced through after STARVE_MAX consecutive LSU wins.
// An IFU cancel lets the AXI transaction finish and suppresses the IFU data strobe.
module c7b_rd_arb #(
   parameter int unsigned GRLEN      = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic             clk,
   input  logic             resetn,
   // IFU side
   input  logic             ifu_rd_req,
   input  logic [GRLEN-1:0] ifu_rd_addr,
   input  logic             ifu_cancel,
   output logic             arb_ifu_rd_ack,
   output logic             arb_ifu_data_valid,
   // LSU side
   input  logic             lsu_rd_req,
   input  logic [GRLEN-1:0] lsu_rd_addr,
   output logic             arb_lsu_rd_ack,
   output logic             arb_lsu_data_valid,
   output logic             arb_lsu_rd_err,
   // Shared read data
   output logic [GRLEN-1:0] arb_rd_data,
   // AXI AR channel
   output logic             ar_valid,
   input  logic             ar_ready,
   output logic [3:0]       ar_id,
   output logic [GRLEN-1:0] ar_addr,
   // AXI R channel
   input  logic             r_valid,
   output logic             r_ready,
   input  logic [GRLEN-1:0] r_data,
   input  logic             r_last,
   input  logic [1:0]       r_resp
);

   // Counter must hold 0..STARVE_MAX; keep at least one bit for STARVE_MAX = 0.
   localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

   // Owner encoding doubles as the low bit of ar_id.
   localparam logic OwnIfu = 1'b0;
   localparam logic OwnLsu = 1'b1;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAddr = 2'd1,
      StData = 2'd2
   } state_e;

   state_e            r_state;
   state_e            w_state_nxt;

   logic              r_owner;
   logic              w_owner_nxt;
   logic [GRLEN-1:0]  r_addr;
   logic [GRLEN-1:0]  w_addr_nxt;
   logic [CntW-1:0]   r_starve_cnt;
   logic [CntW-1:0]   w_starve_nxt;
   logic              r_cancel;
   logic              w_cancel_nxt;

   logic              w_idle;
   logic              w_starved;
   logic              w_grant_ifu;
   logic              w_grant_lsu;
   logic              w_ar_hs;
   logic              w_last_beat;
   logic              w_ifu_busy;
   logic              w_ifu_drop;

   //--------------------------------------------------------------------------
   // Arbitration and handshake decode
   //--------------------------------------------------------------------------
   assign w_idle      = (r_state == StIdle);
   assign w_starved   = (r_starve_cnt == CntMax);
   // IFU only wins when it is alone or has been starved long enough.
   assign w_grant_ifu = w_idle & ifu_rd_req & (~lsu_rd_req | w_starved);
   assign w_grant_lsu = w_idle & lsu_rd_req & ~w_grant_ifu;
   assign w_ar_hs     = (r_state == StAddr) & ar_ready;
   assign w_last_beat = (r_state == StData) & r_valid & r_last;
   // IFU owns an in-flight transaction (address or data phase).
   assign w_ifu_busy  = ~w_idle & (r_owner == OwnIfu);
   // Final IFU beat is dropped if a cancel was latched earlier or arrives with it.
   assign w_ifu_drop  = r_cancel | ifu_cancel;

   //--------------------------------------------------------------------------
   // FSM: state register
   //--------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   //--------------------------------------------------------------------------
   // FSM: next-state logic
   //--------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: begin
            if (ifu_rd_req || lsu_rd_req) begin
               w_state_nxt = StAddr;
            end
         end
         StAddr: begin
            // A cancel never retracts the address; wait for the handshake.
            if (w_ar_hs) begin
               w_state_nxt = StData;
            end
         end
         StData: begin
            // Non-final beats are consumed in place.
            if (w_last_beat) begin
               w_state_nxt = StIdle;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   //--------------------------------------------------------------------------
   // FSM: outputs
   //--------------------------------------------------------------------------
   always_comb begin
      ar_valid           = 1'b0;
      r_ready            = 1'b0;
      arb_ifu_rd_ack     = 1'b0;
      arb_lsu_rd_ack     = 1'b0;
      arb_ifu_data_valid = 1'b0;
      arb_lsu_data_valid = 1'b0;
      arb_lsu_rd_err     = 1'b0;
      unique case (r_state)
         StAddr: begin
            ar_valid       = 1'b1;
            arb_ifu_rd_ack = w_ar_hs & (r_owner == OwnIfu);
            arb_lsu_rd_ack = w_ar_hs & (r_owner == OwnLsu);
         end
         StData: begin
            r_ready            = 1'b1;
            arb_ifu_data_valid = w_last_beat & (r_owner == OwnIfu) & ~w_ifu_drop;
            arb_lsu_data_valid = w_last_beat & (r_owner == OwnLsu);
            // IFU response errors are intentionally not reported.
            arb_lsu_rd_err     = w_last_beat & (r_owner == OwnLsu) & (|r_resp);
         end
         default: begin
         end
      endcase
   end

   // Address and ID come straight from registers so they stay stable under backpressure.
   assign ar_addr     = r_addr;
   assign ar_id       = {3'b000, r_owner};
   assign arb_rd_data = r_data;

   //--------------------------------------------------------------------------
   // Owner/address latch: captured only on a grant
   //--------------------------------------------------------------------------
   always_comb begin
      w_owner_nxt = r_owner;
      w_addr_nxt  = r_addr;
      if (w_grant_ifu) begin
         w_owner_nxt = OwnIfu;
         w_addr_nxt  = ifu_rd_addr;
      end else if (w_grant_lsu) begin
         w_owner_nxt = OwnLsu;
         w_addr_nxt  = lsu_rd_addr;
      end
   end

   //--------------------------------------------------------------------------
   // Starvation counter next value: counts LSU wins over a waiting IFU
   //--------------------------------------------------------------------------
   always_comb begin
      w_starve_nxt = r_starve_cnt;
      if (w_idle) begin
         if (w_grant_ifu) begin
            w_starve_nxt = '0;
         end else if (!ifu_rd_req) begin
            w_starve_nxt = '0;
         end else if (w_grant_lsu && !w_starved) begin
            w_starve_nxt = r_starve_cnt + CntW'(1);
         end
      end
   end

   //--------------------------------------------------------------------------
   // Cancel latch next value: remembers an IFU cancel until the transaction ends
   //--------------------------------------------------------------------------
   always_comb begin
      w_cancel_nxt = r_cancel;
      if (w_state_nxt == StIdle) begin
         w_cancel_nxt = 1'b0;
      end else if (w_ifu_busy && ifu_cancel) begin
         w_cancel_nxt = 1'b1;
      end
   end

   //--------------------------------------------------------------------------
   // Datapath registers
   //--------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_owner      <= OwnIfu;
         r_addr       <= '0;
         r_starve_cnt <= '0;
         r_cancel     <= 1'b0;
      end else begin
         r_owner      <= w_owner_nxt;
         r_addr       <= w_addr_nxt;
         r_starve_cnt <= w_starve_nxt;
         r_cancel     <= w_cancel_nxt;
      end
   end

endmodule

// File: doc/c7b_rd_arb.md
C7B_RD_ARB -- requirements
Module: c7b_rd_arb

Interface
REQ-001 Parameter GRLEN, default 32, address/data width.
REQ-002 Parameter STARVE_MAX, default 4, consecutive LSU grants tolerated while IFU waits.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 ifu_rd_req  in  1  IFU read request; held until acked or withdrawn.
REQ-006 ifu_rd_addr  in  GRLEN  IFU read address.
REQ-007 ifu_cancel  in  1  IFU discards its outstanding fetch.
REQ-008 arb_ifu_rd_ack  out  1  IFU address accepted by AXI.
REQ-009 arb_ifu_data_valid  out  1  IFU read data valid.
REQ-010 lsu_rd_req  in  1  LSU read request; held until acked.
REQ-011 lsu_rd_addr  in  GRLEN  LSU read address.
REQ-012 arb_lsu_rd_ack  out  1  LSU address accepted by AXI.
REQ-013 arb_lsu_data_valid  out  1  LSU read data valid.
REQ-014 arb_lsu_rd_err  out  1  qualifies arb_lsu_data_valid; r_resp nonzero.
REQ-015 arb_rd_data  out  GRLEN  read data, shared by both requesters, equal to r_data.
REQ-016 ar_valid / ar_ready  out / in  1 / 1  AXI AR handshake.
REQ-017 ar_id  out  4  4'd0 for IFU, 4'd1 for LSU.
REQ-018 ar_addr  out  GRLEN  latched request address.
REQ-019 r_valid / r_ready  in / out  1 / 1  AXI R handshake.
REQ-020 r_data  in  GRLEN;  r_last  in  1;  r_resp  in  2.

Function
REQ-021 FSM states: IDLE, ADDR, DATA; exactly one read outstanding at any time.
REQ-022 IDLE with any request: grant, latch owner and address, go to ADDR next cycle.
REQ-022a IDLE with no request: remain in IDLE.
REQ-023 Grant policy: LSU wins over IFU unless starve_cnt == STARVE_MAX and ifu_rd_req = 1, in which case IFU wins.
REQ-024 starve_cnt increments on an LSU grant while ifu_rd_req = 1.
REQ-024a starve_cnt clears on any IFU grant and on any cycle in IDLE with ifu_rd_req = 0.
REQ-024b starve_cnt saturates at STARVE_MAX.
REQ-025 ADDR state: ar_valid = 1; ar_addr and ar_id are stable, driven from registers.
REQ-025a ADDR state: ADDR -> DATA on ar_valid & ar_ready.
REQ-026 arb_<owner>_rd_ack is a 1-cycle pulse in the ar_valid & ar_ready cycle.
REQ-027 Latency: request seen in IDLE at cycle N -> ar_valid at N+1; minimum ack at N+1.
REQ-028 r_ready = 1 only in DATA state; r_valid in IDLE or ADDR is not accepted.
REQ-029 DATA state, r_valid & r_last: arb_<owner>_data_valid = 1 in the same cycle (combinational), then DATA -> IDLE.
REQ-029a DATA state, r_valid & ~r_last: beat consumed, no data_valid, remain in DATA.
REQ-030 Cancel latch: set on ifu_cancel while owner = IFU in ADDR or DATA; cleared on entry to IDLE.
REQ-031 ADDR is never retracted by a cancel; the AR handshake completes and ack is still pulsed.
REQ-032 Final beat with cancel latch set, or with ifu_cancel = 1 in that cycle: arb_ifu_data_valid = 0, and the beat is still consumed.
REQ-033 ifu_cancel while owner = LSU or in IDLE: no effect.
REQ-034 arb_lsu_rd_err = |r_resp on the LSU final beat, else 0; IFU response errors are not reported.
REQ-035 Earliest re-grant is the cycle after returning to IDLE; no same-cycle grant on the final beat.
REQ-036 r_id is not checked.

Reset
REQ-037 resetn = 0 asynchronously forces IDLE, starve_cnt = 0, cancel latch = 0, ar_valid = 0, r_ready = 0, all ack/valid/err outputs = 0.
REQ-037a Registered ar_addr/ar_id reset to 0.
REQ-038 Reset mid-transaction abandons the transaction with no data_valid; AXI slave reset is the system's responsibility.
REQ-039 First grant is possible in the first cycle with resetn = 1.

Verification
REQ-040 Both requests simultaneous in IDLE -> ar_id = 1, LSU ack; IFU granted after LSU data returns.
REQ-041 lsu_rd_req held continuously, ifu_rd_req held, STARVE_MAX = 4 -> 4 LSU grants, 5th grant goes to IFU.
REQ-042 IFU grant, ar_ready low for 3 cycles -> ar_valid, ar_addr, ar_id stable for 4 cycles; single ack pulse.
REQ-043 IFU ifu_cancel in DATA, then r_valid & r_last -> r_ready = 1, arb_ifu_data_valid = 0, FSM returns to IDLE.
REQ-044 LSU read with r_resp = 2'b10 and r_data = 32'hDEADBEEF -> arb_lsu_data_valid = 1, arb_lsu_rd_err = 1, arb_rd_data = 32'hDEADBEEF.
REQ-045 resetn low in ADDR -> ar_valid = 0 immediately, state = IDLE, no ack or valid pulse afterwards.
